// File: rtl/program_memory_loader.sv
// Instruction memory for the BIP core, filled through a byte-serial valid/ready port (high byte first).
// Optional load checksum is built only when PROG_MEM_CHECKSUM_EN is defined.
module program_memory_loader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-ADDR_WIDTH-1:0] OPCODE_HLT = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_input,
    output logic [DATA_WIDTH-1:0] instruction_output,
    output logic                  cpu_enable,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_ready,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic [7:0]            checksum
);

    localparam int DEPTH    = 2**ADDR_WIDTH;
    localparam int OPCODE_W = DATA_WIDTH - ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_HI,
        S_LOAD_LO,
        S_RUN
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_wptr;
    logic [7:0]              r_hi;
    logic [ADDR_WIDTH:0]     r_load_count;
    logic                    r_cpu_enable;
    logic                    r_load_ready;
    logic                    r_rd_valid;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_accept;
    logic                    w_restart;
    logic                    w_wr_en;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic                    w_is_hlt;
    logic                    w_last_addr;

    assign w_accept    = load_valid && r_load_ready;
    // load_start only matters when no load is in progress
    assign w_restart   = load_start && (r_state == S_IDLE || r_state == S_RUN);
    assign w_wr_en     = w_accept && (r_state == S_LOAD_LO);
    assign w_wr_data   = {r_hi, load_byte};
    assign w_is_hlt    = (w_wr_data[DATA_WIDTH-1 -: OPCODE_W] == OPCODE_HLT);
    assign w_last_addr = (r_wptr == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_hi         <= '0;
            r_load_count <= '0;
            r_cpu_enable <= 1'b0;
            r_load_ready <= 1'b0;
        end else if (w_restart) begin
            r_state      <= S_LOAD_HI;
            r_wptr       <= '0;
            r_load_count <= '0;
            r_cpu_enable <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            case (r_state)
                S_LOAD_HI: begin
                    if (w_accept) begin
                        r_hi    <= load_byte;
                        r_state <= S_LOAD_LO;
                    end
                end
                S_LOAD_LO: begin
                    if (w_accept) begin
                        r_load_count <= r_load_count + (ADDR_WIDTH+1)'(1);
                        // pointer saturates on the final slot so it never wraps
                        if (!w_last_addr)
                            r_wptr <= r_wptr + ADDR_WIDTH'(1);
                        if (w_is_hlt || w_last_addr) begin
                            r_state      <= S_RUN;
                            r_load_ready <= 1'b0;
                            r_cpu_enable <= 1'b1;
                        end else begin
                            r_state <= S_LOAD_HI;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Plain clocked RAM so it maps onto block memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wptr] <= w_wr_data;
        r_rd_data <= r_mem[address_input];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rd_valid <= 1'b0;
        else
            r_rd_valid <= (r_state == S_RUN);
    end

    // Outside RUN the core sees HLT, which stalls it safely.
    assign instruction_output = r_rd_valid ? r_rd_data : '0;
    assign cpu_enable         = r_cpu_enable;
    assign load_ready         = r_load_ready;
    assign load_count         = r_load_count;

`ifdef PROG_MEM_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_checksum <= '0;
        else if (w_restart)
            r_checksum <= '0;
        else if (w_accept)
            r_checksum <= r_checksum + load_byte;
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_program_memory_loader.sv
// Randomized scoreboard bench for program_memory_loader: loads programs, then fetches and compares
// against a word-level memory model.
module tb_program_memory_loader;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] address_input = '0;
    logic [15:0] instruction_output;
    logic        cpu_enable;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        load_ready;
    logic [11:0] load_count;
    logic [7:0]  checksum;

    program_memory_loader dut (
        .clk                (clk),
        .reset              (reset),
        .address_input      (address_input),
        .instruction_output (instruction_output),
        .cpu_enable         (cpu_enable),
        .load_start         (load_start),
        .load_valid         (load_valid),
        .load_byte          (load_byte),
        .load_ready         (load_ready),
        .load_count         (load_count),
        .checksum           (checksum)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] model_mem [DEPTH];
    int          last_count = 0;
    logic [15:0] exp_q [$];
    int          addr_q [$];
    logic        fetch_v = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic int exp_checksum(input int sum);
`ifdef PROG_MEM_CHECKSUM_EN
        return sum & 8'hFF;
`else
        return sum & 0;
`endif
    endfunction

    // Monitor: a fetch issued before a rising edge is visible just after it.
    logic [15:0] mon_exp;
    int          mon_addr;
    always @(posedge clk) begin
        if (fetch_v) begin
            #1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL fetch_underflow: got 0x%0h, expected a queued word", instruction_output);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_addr = addr_q.pop_front();
                check($sformatf("fetch[%0d]", mon_addr), int'(instruction_output), int'(mon_exp));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int t;
        repeat (gap) @(negedge clk);
        load_valid = 1'b1;
        load_byte  = b;
        load_start = with_start;
        t = 0;
        while (!load_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!load_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got load_ready=0, expected 1 within 50 cycles");
        end else begin
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        load_byte  = 8'($urandom);
    endtask

    task automatic run_load(input logic [15:0] words [$], input int gapmax,
                            input bit pre_garbage, input bit poke_start, input bit verbose);
        int  cnt;
        int  sum;
        bit  done;
        cnt  = 0;
        sum  = 0;
        done = 0;
        if (pre_garbage) begin
            load_valid = 1'b1;
            repeat (3) begin
                load_byte = 8'($urandom);
                @(negedge clk);
            end
        end
        load_valid = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("start_cpu_enable", int'(cpu_enable), 0);
        check("start_load_ready", int'(load_ready), 1);
        check("start_load_count", int'(load_count), 0);
        foreach (words[i]) begin
            send_byte(words[i][15:8], $urandom_range(gapmax, 0), 1'b0);
            send_byte(words[i][7:0],  $urandom_range(gapmax, 0), poke_start && i == 1);
            sum += int'(words[i][15:8]) + int'(words[i][7:0]);
            model_mem[cnt] = words[i];
            cnt++;
            done = (words[i][15:11] == 5'd0) || (cnt == DEPTH);
            if (done) begin
                check("end_cpu_enable", int'(cpu_enable), 1);
                check("end_load_ready", int'(load_ready), 0);
                check("end_load_count", int'(load_count), cnt);
                check("end_checksum", int'(checksum), exp_checksum(sum));
                break;
            end else if (verbose) begin
                check("mid_cpu_enable", int'(cpu_enable), 0);
            end
        end
        last_count = cnt;
    endtask

    task automatic fetch_one(input int a);
        address_input = 11'(a);
        exp_q.push_back(model_mem[a]);
        addr_q.push_back(a);
        fetch_v = 1'b1;
        @(negedge clk);
    endtask

    task automatic fetch_end();
        fetch_v = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic fetch_random(input int n);
        for (int k = 0; k < n; k++)
            fetch_one($urandom_range(last_count - 1, 0));
        fetch_end();
    endtask

    function automatic logic [15:0] rand_word(input bit hlt);
        logic [4:0] op;
        op = hlt ? 5'd0 : 5'($urandom_range(31, 1));
        return {op, 11'($urandom)};
    endfunction

    initial begin
        logic [15:0] prog [$];
        logic [7:0]  b0, b1;

        #3;
        check("rst_load_ready", int'(load_ready), 0);
        check("rst_cpu_enable", int'(cpu_enable), 0);
        check("rst_load_count", int'(load_count), 0);
        check("rst_instr", int'(instruction_output), 0);
        check("rst_checksum", int'(checksum), 0);
        @(negedge clk);
        reset = 1'b0;

        // Valid bytes while idle must be ignored.
        load_valid = 1'b1;
        repeat (4) begin
            load_byte = 8'($urandom);
            @(negedge clk);
        end
        check("idle_load_ready", int'(load_ready), 0);
        check("idle_load_count", int'(load_count), 0);
        load_valid = 1'b0;

        // Reset after three bytes of a load.
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        b0 = 8'($urandom_range(255, 8));
        b1 = 8'($urandom);
        send_byte(b0, 0, 1'b0);
        send_byte(b1, 1, 1'b0);
        send_byte(8'($urandom), 0, 1'b0);
        model_mem[0] = {b0, b1};
        check("preabort_load_count", int'(load_count), 1);
        #2 reset = 1'b1;
        #1;
        check("abort_load_ready", int'(load_ready), 0);
        check("abort_cpu_enable", int'(cpu_enable), 0);
        check("abort_load_count", int'(load_count), 0);
        check("abort_instr", int'(instruction_output), 0);
        check("abort_checksum", int'(checksum), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic program with gaps and pre-start garbage.
        prog = '{16'h0805, 16'h1003, 16'h0000};
        run_load(prog, 3, 1'b1, 1'b0, 1'b1);
        check("basic_count", last_count, 3);
        fetch_one(0);
        fetch_one(1);
        fetch_one(2);
        fetch_end();

        // Random programs, some with load_start poked mid-load.
        for (int p = 0; p < 6; p++) begin
            int len;
            len = $urandom_range(12, 1);
            prog.delete();
            for (int w = 0; w < len; w++)
                prog.push_back(rand_word(1'b0));
            prog.push_back(rand_word(1'b1));
            run_load(prog, p % 3, p[0], p >= 3, 1'b0);
            fetch_random(6);
        end

        // Reload from RUN.
        prog = '{16'h1807, 16'h0000};
        run_load(prog, 2, 1'b0, 1'b0, 1'b1);
        fetch_one(0);
        fetch_one(1);
        fetch_end();

        // Full-depth load without any HLT.
        prog.delete();
        for (int w = 0; w < DEPTH; w++)
            prog.push_back(16'h0800 + 16'(w));
        run_load(prog, 0, 1'b0, 1'b0, 1'b0);
        check("full_count", last_count, DEPTH);
        fetch_one(DEPTH - 1);
        fetch_one(0);
        fetch_end();
        fetch_random(10);

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL fetch_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
